// File: rtl/dtlb_resp.sv
// dtlb_resp: fully-associative data-TLB with same-cycle lookup of key and key+1, walker refill, round-robin fill.
// Optional DTLB_PERF_EN adds saturating perf_hit/perf_miss counters with perf_clr.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

module dtlb_resp #(
  parameter int ENTRIES    = 16,
  parameter int DATA_WIDTH = `dtlbData_width,
  parameter int KEY_WIDTH  = 52
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_WIDTH-1:0]  addrTlb,
  input  logic                  tlb_clkEn,
  input  logic                  next_req,
  output logic [DATA_WIDTH-1:0] tlb_data0,
  output logic [DATA_WIDTH-1:0] tlb_data1,
  output logic                  tlb_hit,
  output logic                  walk_req,
  output logic [KEY_WIDTH-1:0]  walk_key,
  input  logic                  walk_ack,
  input  logic [DATA_WIDTH-1:0] walk_data,
  input  logic                  walk_fault,
  input  logic                  inv_all,
  output logic                  busy
`ifdef DTLB_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           perf_hit,
  output logic [31:0]           perf_miss
`endif
);
  localparam int RW = $clog2(ENTRIES);
  typedef enum logic [1:0] {IDLE, REQ0, REQ1, FILL} state_t;
  state_t state, nxt;
  logic [ENTRIES-1:0] valid, m0, m1;
  logic [KEY_WIDTH-1:0] tag [ENTRIES];
  logic [DATA_WIDTH-1:0] pay [ENTRIES];
  logic [RW-1:0] rr;
  logic [KEY_WIDTH-1:0] key1;
  logic [DATA_WIDTH-1:0] wdata;
  logic hit0, hit1, need1, from0, fault, sup, wr;

  // The proc field never carries; only the page-number bits wrap.
  function automatic logic [KEY_WIDTH-1:0] inc(input logic [KEY_WIDTH-1:0] k);
    return {k[KEY_WIDTH-1:31], k[30:0] + 31'd1};
  endfunction

  assign key1 = inc(addrTlb);

  always_comb begin
    m0 = '0;
    m1 = '0;
    tlb_data0 = '0;
    tlb_data1 = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      m0[i] = valid[i] && tag[i] == addrTlb;
      m1[i] = valid[i] && tag[i] == key1;
      tlb_data0 = tlb_data0 | (m0[i] ? pay[i] : '0);
      tlb_data1 = tlb_data1 | (m1[i] ? pay[i] : '0);
    end
  end

  assign hit0 = |m0;
  assign hit1 = |m1;

  assert property (@(posedge clk) disable iff (rst) $onehot0(m0) && $onehot0(m1));

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = !tlb_clkEn ? IDLE : !hit0 ? REQ0 : (next_req && !hit1) ? REQ1 : IDLE;
      REQ0, REQ1: nxt = walk_ack ? FILL : state;
      FILL: nxt = (from0 && need1 && !fault) ? REQ1 : IDLE;
    endcase
  end

  always_comb begin
    walk_req = state == REQ0 || state == REQ1;
    busy = state != IDLE;
    tlb_hit = tlb_clkEn && hit0 && (hit1 || !next_req) && state == IDLE;
    wr = state == FILL && !fault && !sup && !inv_all;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      walk_key <= '0;
      need1 <= 1'b0;
      from0 <= 1'b0;
      fault <= 1'b0;
      sup <= 1'b0;
      wdata <= '0;
      valid <= '0;
      rr <= '0;
    end else begin
      if (state == IDLE && nxt == REQ0) begin
        walk_key <= addrTlb;
        need1 <= next_req && !hit1;
      end
      if (state == IDLE && nxt == REQ1) walk_key <= key1;
      if (state == FILL && nxt == REQ1) walk_key <= inc(walk_key);
      if (walk_req && walk_ack) begin
        wdata <= walk_data;
        fault <= walk_fault;
        from0 <= state == REQ0;
      end
      // An invalidate seen while the walk is outstanding cancels its fill.
      sup <= walk_req && (sup || inv_all);
      valid <= inv_all ? '0 : wr ? valid | (ENTRIES'(1) << rr) : valid;
      if (wr) rr <= rr + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (wr) begin
      tag[rr] <= walk_key;
      pay[rr] <= wdata;
    end

`ifdef DTLB_PERF_EN
  always_ff @(posedge clk)
    if (rst || perf_clr) begin
      perf_hit <= '0;
      perf_miss <= '0;
    end else begin
      if (tlb_hit && !(&perf_hit)) perf_hit <= perf_hit + 32'd1;
      if (state == IDLE && nxt != IDLE && !(&perf_miss)) perf_miss <= perf_miss + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dtlb_resp.sv
// tb_dtlb_resp: directed and randomized checks of dtlb_resp against a FIFO-of-pages reference model.
module tb_dtlb_resp;
  localparam int DW = 64, KW = 52, N = 16;
  logic clk = 0, rst = 1;
  logic [KW-1:0] addrTlb = '0, walk_key;
  logic tlb_clkEn = 0, next_req = 0, walk_ack = 0, walk_fault = 0, inv_all = 0;
  logic [DW-1:0] tlb_data0, tlb_data1, walk_data = '0;
  logic tlb_hit, walk_req, busy;
`ifdef DTLB_PERF_EN
  logic perf_clr = 0;
  logic [31:0] perf_hit, perf_miss;
`endif
  int pass_cnt = 0, total = 0;

  dtlb_resp #(.ENTRIES(N), .DATA_WIDTH(DW), .KEY_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .addrTlb(addrTlb), .tlb_clkEn(tlb_clkEn), .next_req(next_req),
    .tlb_data0(tlb_data0), .tlb_data1(tlb_data1), .tlb_hit(tlb_hit), .walk_req(walk_req),
    .walk_key(walk_key), .walk_ack(walk_ack), .walk_data(walk_data), .walk_fault(walk_fault),
    .inv_all(inv_all), .busy(busy)
`ifdef DTLB_PERF_EN
    , .perf_clr(perf_clr), .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [KW-1:0] k; logic [DW-1:0] d;} ent_t;
  ent_t q[$];

  function automatic logic [KW-1:0] kinc(input logic [KW-1:0] k);
    return {k[51:31], k[30:0] + 31'd1};
  endfunction

  function automatic bit m_find(input logic [KW-1:0] k, output logic [DW-1:0] d);
    d = '0;
    foreach (q[i]) if (q[i].k == k) begin
      d = q[i].d;
      return 1;
    end
    return 0;
  endfunction

  function automatic void m_put(input logic [KW-1:0] kk, input logic [DW-1:0] dd);
    q.push_back('{kk, dd});
    if (q.size() > N) void'(q.pop_front());
  endfunction

  task automatic do_reset();
    rst = 1; tlb_clkEn = 0; next_req = 0; walk_ack = 0; inv_all = 0; addrTlb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q.delete();
  endtask

  task automatic lookup(input logic [KW-1:0] k, input bit nr, input bit en,
                        output logic h, output logic [DW-1:0] d0, output logic [DW-1:0] d1);
    @(negedge clk);
    addrTlb = k; next_req = nr; tlb_clkEn = en;
    #2 h = tlb_hit; d0 = tlb_data0; d1 = tlb_data1;
    @(posedge clk);
    #1 tlb_clkEn = 0; next_req = 0;
  endtask

  task automatic do_walk(input logic [DW-1:0] d, input bit f, output logic [KW-1:0] k,
                         output bit ok, output int n);
    ok = 0; n = -1; k = '0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      #2 if (walk_req) begin
        k = walk_key; n = i; ok = 1;
        walk_ack = 1; walk_data = d; walk_fault = f;
        @(posedge clk);
        #1 walk_ack = 0; walk_fault = 0;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      #2 ok = !busy;
    end
  endtask

  localparam logic [KW-1:0] K0 = {21'd1, 31'h10};
  localparam logic [DW-1:0] D1 = 64'hD1D1_0000_1111_2222, D2 = 64'hD2D2_3333_4444_5555;

  task automatic test_reset();
    rst = 1; tlb_clkEn = 1; addrTlb = K0;
    @(negedge clk);
    #2 total++; if (tlb_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", tlb_hit); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (walk_req !== 1'b0) $display("FAIL reset_walk_req: got %b want 0", walk_req); else pass_cnt++;
    total++; if (walk_key !== '0) $display("FAIL reset_walk_key: got %h want 0", walk_key); else pass_cnt++;
    @(posedge clk);
    #1 rst = 0; tlb_clkEn = 0;
    q.delete();
    @(negedge clk);
    #2 total++; if (busy !== 1'b0) $display("FAIL reset_no_walk: got busy %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic h; logic [DW-1:0] d0, d1; logic [KW-1:0] k; bit ok; int n;
    lookup(K0, 0, 1, h, d0, d1);
    total++; if (h !== 1'b0) $display("FAIL basic_miss: got %b want 0", h); else pass_cnt++;
    do_walk(D1, 0, k, ok, n);
    total++; if (!ok || k !== K0) $display("FAIL basic_walk_key: got %h (ok=%0b) want %h", k, ok, K0); else pass_cnt++;
    m_put(K0, D1);
    lookup(K0, 0, 1, h, d0, d1);
    total++; if (h !== 1'b0) $display("FAIL basic_fill_cycle: got %b want 0", h); else pass_cnt++;
    lookup(K0, 0, 0, h, d0, d1);
    total++; if (h !== 1'b0) $display("FAIL basic_noen: got %b want 0", h); else pass_cnt++;
    total++; if (d0 !== D1) $display("FAIL basic_noen_data: got %h want %h", d0, D1); else pass_cnt++;
    lookup(K0, 0, 1, h, d0, d1);
    total++; if (h !== 1'b1 || d0 !== D1) $display("FAIL basic_hit: got %b/%h want 1/%h", h, d0, D1); else pass_cnt++;
  endtask

  task automatic test_next();
    logic h; logic [DW-1:0] d0, d1; logic [KW-1:0] k; bit ok; int n;
    lookup(K0, 1, 1, h, d0, d1);
    total++; if (h !== 1'b0 || d0 !== D1) $display("FAIL next_miss: got %b/%h want 0/%h", h, d0, D1); else pass_cnt++;
    do_walk(D2, 0, k, ok, n);
    total++; if (!ok || k !== kinc(K0)) $display("FAIL next_walk_key: got %h want %h", k, kinc(K0)); else pass_cnt++;
    m_put(kinc(K0), D2);
    wait_idle(ok);
    total++; if (!ok) $display("FAIL next_idle: got busy want idle"); else pass_cnt++;
    lookup(K0, 1, 1, h, d0, d1);
    total++; if (h !== 1'b1 || d0 !== D1 || d1 !== D2)
      $display("FAIL next_hit: got %b/%h/%h want 1/%h/%h", h, d0, d1, D1, D2); else pass_cnt++;
  endtask

  task automatic test_double(input logic [KW-1:0] kk, input string nm);
    logic h; logic [DW-1:0] d0, d1, da, db; logic [KW-1:0] k; bit ok; int n;
    da = {$urandom, $urandom}; db = {$urandom, $urandom};
    lookup(kk, 1, 1, h, d0, d1);
    total++; if (h !== 1'b0) $display("FAIL %s_miss: got %b want 0", nm, h); else pass_cnt++;
    do_walk(da, 0, k, ok, n);
    total++; if (!ok || k !== kk) $display("FAIL %s_walk0: got %h want %h", nm, k, kk); else pass_cnt++;
    @(negedge clk);
    #2 total++; if (busy !== 1'b1 || walk_req !== 1'b0)
      $display("FAIL %s_fill: got busy %b req %b want 1 0", nm, busy, walk_req); else pass_cnt++;
    do_walk(db, 0, k, ok, n);
    total++; if (!ok || n != 0 || k !== kinc(kk))
      $display("FAIL %s_walk1: got %h after %0d want %h after 0", nm, k, n, kinc(kk)); else pass_cnt++;
    m_put(kk, da); m_put(kinc(kk), db);
    wait_idle(ok);
    lookup(kk, 1, 1, h, d0, d1);
    total++; if (!ok || h !== 1'b1 || d0 !== da || d1 !== db)
      $display("FAIL %s_hit: got %b/%h/%h want 1/%h/%h", nm, h, d0, d1, da, db); else pass_cnt++;
  endtask

  task automatic test_evict();
    logic h; logic [DW-1:0] d0, d1; logic [KW-1:0] k, kk; bit ok, ok2; int n, bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      kk = {21'd5, 31'(i * 7 + 1)};
      lookup(kk, 0, 1, h, d0, d1);
      do_walk({32'hE, 32'(i)}, 0, k, ok, n);
      wait_idle(ok2);
      if (h !== 1'b0 || !ok || !ok2 || k !== kk) bad++;
    end
    total++; if (bad != 0) $display("FAIL evict_fill: got %0d bad fills want 0", bad); else pass_cnt++;
    bad = 0;
    for (int i = 1; i < 17; i++) begin
      lookup({21'd5, 31'(i * 7 + 1)}, 0, 1, h, d0, d1);
      if (h !== 1'b1 || d0 !== {32'hE, 32'(i)}) bad++;
    end
    total++; if (bad != 0) $display("FAIL evict_keep: got %0d misses want 0", bad); else pass_cnt++;
    lookup({21'd5, 31'd1}, 0, 1, h, d0, d1);
    total++; if (h !== 1'b0 || d0 !== '0) $display("FAIL evict_first: got %b/%h want 0/0", h, d0); else pass_cnt++;
    do_walk('0, 1, k, ok, n);
    wait_idle(ok);
    total++; if (!ok) $display("FAIL evict_fault_idle: got busy want idle"); else pass_cnt++;
  endtask

  task automatic test_inv();
    logic h; logic [DW-1:0] d0, d1; logic [KW-1:0] k; bit ok; int n;
    logic [KW-1:0] k5 = {21'd7, 31'h55}, k6 = {21'd7, 31'h66};
    lookup(k5, 0, 1, h, d0, d1);
    do_walk(64'h5555, 0, k, ok, n);
    @(negedge clk); inv_all = 1;
    @(posedge clk); #1 inv_all = 0;
    q.delete();
    wait_idle(ok);
    lookup(k5, 0, 1, h, d0, d1);
    total++; if (h !== 1'b0 || d0 !== '0) $display("FAIL inv_fill: got %b/%h want 0/0", h, d0); else pass_cnt++;
    do_walk('0, 1, k, ok, n);
    total++; if (!ok || k !== k5) $display("FAIL inv_rewalk: got %h want %h", k, k5); else pass_cnt++;
    wait_idle(ok);
    total++; if (!ok) $display("FAIL inv_fault_idle: got busy want idle"); else pass_cnt++;
    lookup(k5, 0, 1, h, d0, d1);
    total++; if (h !== 1'b0) $display("FAIL inv_fault_noinstall: got %b want 0", h); else pass_cnt++;
    do_walk('0, 1, k, ok, n);
    wait_idle(ok);
    lookup(k6, 0, 1, h, d0, d1);
    @(negedge clk);
    #2 total++; if (walk_req !== 1'b1) $display("FAIL inv_req: got %b want 1", walk_req); else pass_cnt++;
    inv_all = 1;
    @(posedge clk); #1 inv_all = 0;
    do_walk(64'h6666, 0, k, ok, n);
    wait_idle(ok);
    lookup(k6, 0, 1, h, d0, d1);
    total++; if (!ok || h !== 1'b0 || d0 !== '0) $display("FAIL inv_req_suppress: got %b/%h want 0/0", h, d0); else pass_cnt++;
    do_walk('0, 1, k, ok, n);
    wait_idle(ok);
  endtask

  task automatic test_misc();
    logic h; logic [DW-1:0] d0, d1; logic [KW-1:0] k7 = {21'd9, 31'h77};
    @(negedge clk); walk_ack = 1; walk_data = 64'hBAD;
    @(posedge clk); #1 walk_ack = 0;
    @(negedge clk);
    #2 total++; if (busy !== 1'b0) $display("FAIL stray_ack: got busy %b want 0", busy); else pass_cnt++;
    lookup(k7, 0, 1, h, d0, d1);
    @(negedge clk);
    #2 total++; if (walk_req !== 1'b1) $display("FAIL midreset_req: got %b want 1", walk_req); else pass_cnt++;
    rst = 1;
    @(posedge clk); #1 rst = 0;
    q.delete();
    @(negedge clk); walk_ack = 1; walk_data = 64'h7777;
    @(posedge clk); #1 walk_ack = 0;
    @(negedge clk);
    #2 total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else pass_cnt++;
    lookup(k7, 0, 0, h, d0, d1);
    total++; if (d0 !== '0) $display("FAIL midreset_noinstall: got %h want 0", d0); else pass_cnt++;
  endtask

  task automatic test_random();
    logic h; logic [DW-1:0] d0, d1, e0, e1, rd; logic [KW-1:0] key, k; bit ok, h0, h1, nr, f; int n;
    logic [30:0] lows [10] = '{31'h7FFFFFFF, 31'h7FFFFFFE, 0, 1, 2, 3, 4, 5, 6, 7};
    do_reset();
    for (int it = 0; it < 80; it++) begin
      key = {21'(1 + $urandom % 2), lows[$urandom % 10]};
      nr = $urandom % 2;
      h0 = m_find(key, e0);
      h1 = m_find(kinc(key), e1);
      lookup(key, nr, 1, h, d0, d1);
      total++; if (h !== (h0 && (h1 || !nr)) || d0 !== e0 || d1 !== e1)
        $display("FAIL rand_lookup %h: got %b/%h/%h want %b/%h/%h", key, h, d0, d1, h0 && (h1 || !nr), e0, e1);
      else pass_cnt++;
      if (!h0) begin
        rd = {$urandom, $urandom}; f = ($urandom % 6) == 0;
        do_walk(rd, f, k, ok, n);
        total++; if (!ok || k !== key) $display("FAIL rand_walk0: got %h want %h", k, key); else pass_cnt++;
        if (!f) m_put(key, rd);
        if (!f && nr && !h1) begin
          rd = {$urandom, $urandom}; f = ($urandom % 6) == 0;
          do_walk(rd, f, k, ok, n);
          total++; if (!ok || k !== kinc(key)) $display("FAIL rand_walk1: got %h want %h", k, kinc(key)); else pass_cnt++;
          if (!f) m_put(kinc(key), rd);
        end
      end else if (nr && !h1) begin
        rd = {$urandom, $urandom}; f = ($urandom % 6) == 0;
        do_walk(rd, f, k, ok, n);
        total++; if (!ok || k !== kinc(key)) $display("FAIL rand_walk_next: got %h want %h", k, kinc(key)); else pass_cnt++;
        if (!f) m_put(kinc(key), rd);
      end
      wait_idle(ok);
      total++; if (!ok) $display("FAIL rand_idle: got busy want idle"); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_next();
    test_double({21'd3, 31'h100}, "double");
    test_double({21'h1ABCD, 31'h7FFFFFFF}, "wrap");
    test_evict();
    test_inv();
    test_misc();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/dtlb_resp.md
Name: dtlb_resp

Overview:
- Data-TLB responder serving the store AGU's lookup interface.
- Takes the 52-bit lookup key {proc[20:0], va[43:13]} with its enable.
- Returns translation data for the addressed 8 KB page and for the following page (split accesses), plus a hit flag, in the same cycle.
- On a miss it runs a refill handshake with the page walker and installs the result with round-robin replacement.

Parameters:
- ENTRIES, 16, number of fully-associative entries (power of 2, 4..64).
- DATA_WIDTH, `dtlbData_width, translation payload width (phys/type/sys/na/wp fields).
- KEY_WIDTH, 52, lookup key width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addrTlb  in  KEY_WIDTH  lookup key {proc[20:0], va[43:13]}
- tlb_clkEn  in  1  lookup valid
- next_req  in  1  access may cross into page key+1
- tlb_data0  out  DATA_WIDTH  payload for key
- tlb_data1  out  DATA_WIDTH  payload for key+1
- tlb_hit  out  1  lookup satisfied
- walk_req  out  1  refill request to page walker
- walk_key  out  KEY_WIDTH  key being walked
- walk_ack  in  1  walker response valid
- walk_data  in  DATA_WIDTH  walker payload
- walk_fault  in  1  walker found no mapping
- inv_all  in  1  invalidate every entry (csr_page/csr_vmpage write)
- busy  out  1  refill FSM not IDLE

Behaviour:
- Key+1 = {key[51:31], key[30:0]+1}. The proc field never carries; the low 31 bits wrap from all-ones to zero.
- Lookup is combinational from addrTlb: hit0/hit1 = any valid entry whose tag equals key / key+1.
- Entry match uses a one-hot select. More than one match is illegal and is flagged by a simulation assertion.
- tlb_data0/tlb_data1 carry the matching entry payload, or 0 on miss.
- tlb_hit = tlb_clkEn & hit0 & (hit1 | ~next_req) & (state==IDLE).
- tlb_hit is 0 whenever tlb_clkEn=0.
- Reset: all valid bits 0, rr pointer 0, state IDLE, walk_req=0, walk_key=0, busy=0, tlb_hit=0. Reset mid-refill abandons the walk; a later walk_ack is ignored.
- FSM states: IDLE, REQ0, REQ1, FILL.
  - IDLE:
    - On tlb_clkEn & ~hit0: latch walk_key=key, remember need1=next_req & ~hit1, go to REQ0.
    - On tlb_clkEn & hit0 & next_req & ~hit1: latch walk_key=key+1, go to REQ1.
    - Lookups arriving while not IDLE get tlb_hit=0. Requesters retry.
  - REQ0/REQ1:
    - walk_req=1, held until walk_ack; walk_key stable.
    - On walk_ack, register walk_data/walk_fault, go to FILL.
  - FILL (1 cycle):
    - If ~fault: write {valid, tag=walk_key, data} at rr, rr<=rr+1 (mod ENTRIES).
    - Faulting walks install nothing. The AGU sees the fault via a later retry miss handled by the walker.
    - Then: if the previous state was REQ0 and need1 and ~fault, set walk_key=old key+1 and go to REQ1. Otherwise go to IDLE.
- inv_all: clears all valid bits next edge.
  - If asserted the same cycle as a FILL write, the invalidate wins: the entry is not left valid.
  - If asserted during REQx, the walk completes but its FILL is suppressed.
- walk_ack outside REQ0/REQ1 is ignored.
- Fill and lookup of the same key in the same cycle: the lookup sees pre-write contents (miss). Hit follows next cycle.

Optional Feature:
- DTLB_PERF_EN defined: adds 32-bit saturating counters perf_hit and perf_miss (outputs), plus perf_clr input (synchronous clear).
  - perf_hit increments on tlb_hit.
  - perf_miss increments on each IDLE→REQx transition.
  - Reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, lookup key 0x000001_00000010 with clkEn → tlb_hit=0. Next cycle walk_req=1, walk_key=same. Ack with data D1 → after FILL, same lookup gives tlb_hit=1, tlb_data0=D1.
- Entry for K installed, lookup K with next_req=1 and K+1 absent → tlb_hit=0, walk_key=K+1. After ack D2, lookup gives data0=D1, data1=D2, hit=1.
- Both K and K+1 absent, next_req=1 → two consecutive walks (K then K+1) without returning to IDLE between. Final lookup hits.
- Key low bits 0x7FFFFFFF with next_req=1 → second walk key has low 31 bits 0x00000000 and unchanged proc field.
- Fill 17 distinct keys into 16 entries → first key now misses, keys 2..17 hit (round-robin wrap).
- inv_all asserted in the FILL cycle → entry not valid. Subsequent lookup misses and issues a new walk_req. walk_fault=1 ack → nothing installed, busy returns 0.
